wgt_feeder: RTL and testbench
=============================

# wgt_feeder

Weight-side producer for the 4-deep weight shift buffer in front of the PE array. On a start command it fetches `num_tiles` tiles of four signed 8-bit weights from the weight SRAM (1-cycle read latency) and serially shifts each tile into the buffer using the `wgt_input`/`wgt_read` pair. After each tile it raises `tile_valid` and holds off the next tile until the compute side returns `tile_ack`, so weights in use are never overwritten.

## Interface
- ADDR_W, 10, weight SRAM word-address width
- TILE_W, 8, width of the tile-count input
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle command pulse; sampled only in IDLE
- base_addr  input  ADDR_W  address of word 0 of tile 0; captured with start
- num_tiles  input  TILE_W  tiles to load; captured with start
- mem_ren  output  1  SRAM read enable
- mem_addr  output  ADDR_W  SRAM read address
- mem_rdata  input  8  signed SRAM data, valid the cycle after mem_ren
- wgt_input  output  8  signed weight to buffer
- wgt_read  output  1  buffer shift strobe
- tile_valid  output  1  one-cycle pulse: buffer holds a complete new tile
- tile_idx  output  TILE_W  index of tile most recently completed
- tile_ack  input  1  consumer finished with current tile
- busy  output  1  command in progress
- done  output  1  one-cycle pulse: command complete

## Operation
- States: IDLE, FETCH, FLUSH, WAIT_ACK, DONE.
- IDLE: `start`=1 captures base_addr, num_tiles; clears tile counter; -> FETCH. If num_tiles=0 -> DONE instead (no SRAM reads).
- FETCH: 4 cycles, `mem_ren`=1, `mem_addr` = running address, +1 per cycle. Running address is not reset between tiles: tile k occupies base_addr+4k..+4k+3. Address wraps modulo 2^ADDR_W.
- `mem_rdata` registered into `wgt_input`; `wgt_read` is `mem_ren` delayed 2 cycles. Word issued first ends in buffer slot 3, last in slot 0.
- FLUSH: 2 cycles waiting for the last word to be shifted; then `tile_valid` pulses, `tile_idx` = tile counter, -> WAIT_ACK.
- WAIT_ACK: hold, `wgt_read`=0. On `tile_ack`=1: counter+1; if counter+1 < num_tiles -> FETCH, else -> DONE.
- DONE: one cycle, `done`=1, `busy`=0, -> IDLE.
- `start` outside IDLE ignored; `tile_ack` outside WAIT_ACK ignored. tile_ack in the same cycle as tile_valid is accepted.
- Width: counter compare is unsigned TILE_W bits; num_tiles=2^TILE_W-1 valid.

## Timing
- Reset (async): state IDLE; mem_ren, mem_addr, wgt_input, wgt_read, tile_valid, tile_idx, busy, done all 0. Reset mid-command aborts immediately; no further strobes.
- start high in cycle 0 -> busy high from cycle 1; mem_ren cycles 1-4 (addr base..base+3); mem_rdata cycles 2-5; wgt_read cycles 3-6; tile_valid cycle 7.
- tile_ack high in cycle n (non-last tile) -> mem_ren cycles n+1..n+4, tile_valid cycle n+7. Minimum tile period 7 cycles.
- tile_ack on last tile in cycle n -> done cycle n+1, busy 0 from cycle n+1; new start accepted from cycle n+2.
- num_tiles=0: start in cycle 0 -> done cycle 1, busy never high, mem_ren never high.
- wgt_read never high while in WAIT_ACK, DONE or IDLE.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release, no activity until start.
- Single tile: SRAM[0x10..0x13]=1,-2,3,-4, base=0x10, num=1 -> mem_ren cycles 1-4, wgt_read 3-6 with 1,-2,3,-4, tile_valid cycle 7, buffer slots 3..0 = 1,-2,3,-4; ack cycle 9 -> done cycle 10.
- Three tiles, ack delayed 5 cycles each -> addresses base..base+11 contiguous, tile_idx 0,1,2, no wgt_read during waits, exactly 12 strobes, one done.
- Wrap: base=0x3FE, num=1 -> addresses 0x3FE,0x3FF,0x000,0x001.
- num_tiles=0 and start while busy -> done cycle 1 with no reads; second start mid-command has no effect on addresses or counts.
- Reset mid-FETCH (cycle 3) -> outputs 0 next instant; later start runs a clean full command.

Source files
------------

// File: rtl/wgt_feeder_if.sv
// Bus between wgt_feeder and its environment: command, weight SRAM read port,
// weight shift-buffer strobes and the tile handshake with the compute side.
interface wgt_feeder_if #(
    parameter int ADDR_W = 10,
    parameter int TILE_W = 8,
    parameter int DATA_W = 8
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [TILE_W-1:0]        num_tiles;
    logic                     mem_ren;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_rdata;
    logic signed [DATA_W-1:0] wgt_input;
    logic                     wgt_read;
    logic                     tile_valid;
    logic [TILE_W-1:0]        tile_idx;
    logic                     tile_ack;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, base_addr, num_tiles, mem_rdata, tile_ack,
        output mem_ren, mem_addr, wgt_input, wgt_read, tile_valid, tile_idx, busy, done
    );

    modport slave (
        output start, base_addr, num_tiles, mem_rdata, tile_ack,
        input  mem_ren, mem_addr, wgt_input, wgt_read, tile_valid, tile_idx, busy, done
    );
endinterface

// File: rtl/wgt_feeder.sv
// Fetches tiles of four signed weights from SRAM and shifts them serially into
// the 4-deep weight buffer, holding each tile until the compute side acks it.
module wgt_feeder #(
    parameter int ADDR_W = 10,
    parameter int TILE_W = 8,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wgt_feeder_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, FLUSH, WAIT_ACK, DONE} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        run_addr;
    logic [ADDR_W-1:0]        mem_addr_r;
    logic [TILE_W-1:0]        num_r;
    logic [TILE_W-1:0]        cnt;
    logic [TILE_W-1:0]        tile_idx_r;
    logic [TILE_W:0]          cnt_nxt;
    logic [1:0]               beat;
    logic                     mem_ren_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     tile_valid_r;
    logic                     vld_p0;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] data_p1;

    // One extra bit so the last-tile compare cannot wrap at num_tiles = 2^TILE_W-1.
    assign cnt_nxt = {1'b0, cnt} + (TILE_W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            run_addr     <= '0;
            mem_addr_r   <= '0;
            num_r        <= '0;
            cnt          <= '0;
            tile_idx_r   <= '0;
            beat         <= '0;
            mem_ren_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            tile_valid_r <= 1'b0;
        end else begin
            tile_valid_r <= 1'b0;
            done_r       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        num_r <= bus.num_tiles;
                        cnt   <= '0;
                        if (bus.num_tiles == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            busy_r     <= 1'b1;
                            mem_ren_r  <= 1'b1;
                            mem_addr_r <= bus.base_addr;
                            run_addr   <= bus.base_addr + ADDR_W'(1);
                            beat       <= '0;
                        end
                    end
                end
                FETCH: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        mem_ren_r <= 1'b0;
                        state     <= FLUSH;
                        beat      <= '0;
                    end else begin
                        mem_addr_r <= run_addr;
                        run_addr   <= run_addr + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    // Two cycles cover SRAM latency plus the input register.
                    beat <= beat + 2'd1;
                    if (beat == 2'd1) begin
                        tile_valid_r <= 1'b1;
                        tile_idx_r   <= cnt;
                        state        <= WAIT_ACK;
                        beat         <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (bus.tile_ack) begin
                        cnt <= cnt_nxt[TILE_W-1:0];
                        if (cnt_nxt < {1'b0, num_r}) begin
                            state      <= FETCH;
                            mem_ren_r  <= 1'b1;
                            mem_addr_r <= run_addr;
                            run_addr   <= run_addr + ADDR_W'(1);
                            beat       <= '0;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            // p0: SRAM access in flight, data returns this cycle
            vld_p0 <= mem_ren_r;
            // p1: registered weight presented to the buffer with its shift strobe
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_ren    = mem_ren_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.wgt_input  = data_p1;
    assign bus.wgt_read   = vld_p1;
    assign bus.tile_valid = tile_valid_r;
    assign bus.tile_idx   = tile_idx_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_wgt_feeder.sv
// Randomized bench for wgt_feeder: SRAM model, event monitor and a tile-level
// reference that predicts every strobe cycle, address and weight.
module tb_wgt_feeder;
    localparam int ADDR_W = 10;
    localparam int TILE_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wgt_feeder_if #(.ADDR_W(ADDR_W), .TILE_W(TILE_W), .DATA_W(DATA_W)) bus ();

    wgt_feeder #(.ADDR_W(ADDR_W), .TILE_W(TILE_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with one cycle of read latency; garbage on the bus when not read.
    logic signed [DATA_W-1:0] sram [0:DEPTH-1];
    logic                     ren_q  = 1'b0;
    logic [ADDR_W-1:0]        addr_q = '0;
    always @(posedge clk) begin
        ren_q  <= bus.mem_ren;
        addr_q <= bus.mem_addr;
    end
    always @(negedge clk) bus.mem_rdata <= ren_q ? sram[addr_q] : DATA_W'($urandom);

    int          ren_cyc[$], ren_addr[$], rd_cyc[$], rd_data[$];
    int          tv_cyc[$], tv_idx[$], done_cyc[$], busy_cyc[$];
    logic [31:0] tv_buf[$];
    logic signed [DATA_W-1:0] shadow [4];

    always @(negedge clk) begin
        if (bus.mem_ren) begin
            ren_cyc.push_back(cyc);
            ren_addr.push_back(int'(bus.mem_addr));
        end
        if (bus.wgt_read) begin
            rd_cyc.push_back(cyc);
            rd_data.push_back(int'(bus.wgt_input));
            shadow[0] <= bus.wgt_input;
            shadow[1] <= shadow[0];
            shadow[2] <= shadow[1];
            shadow[3] <= shadow[2];
        end
        if (bus.tile_valid) begin
            tv_cyc.push_back(cyc);
            tv_idx.push_back(int'(bus.tile_idx));
            tv_buf.push_back({shadow[3], shadow[2], shadow[1], shadow[0]});
        end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.busy) busy_cyc.push_back(cyc);
    end

    task automatic chk_val(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_val({tag, ".mem_ren"},    bus.mem_ren,    0);
        chk_val({tag, ".mem_addr"},   bus.mem_addr,   0);
        chk_val({tag, ".wgt_input"},  bus.wgt_input,  0);
        chk_val({tag, ".wgt_read"},   bus.wgt_read,   0);
        chk_val({tag, ".tile_valid"}, bus.tile_valid, 0);
        chk_val({tag, ".tile_idx"},   bus.tile_idx,   0);
        chk_val({tag, ".busy"},       bus.busy,       0);
        chk_val({tag, ".done"},       bus.done,       0);
    endtask

    // dly < 0 picks a random ack delay per tile; noise toggles start/tile_ack
    // and command fields while the DUT is fetching or flushing.
    task automatic run_cmd(input logic [ADDR_W-1:0] base, input logic [TILE_W-1:0] num,
                           input int dly, input bit noise);
        int s, n, f, d, a, i, waited, ack_last;
        int ack_c[$];
        bit seen, hung;
        logic [31:0] eb;
        n = int'(num);
        @(negedge clk);
        ren_cyc.delete(); ren_addr.delete(); rd_cyc.delete(); rd_data.delete();
        tv_cyc.delete(); tv_idx.delete(); tv_buf.delete(); done_cyc.delete(); busy_cyc.delete();
        bus.start = 1'b1; bus.base_addr = base; bus.num_tiles = num; bus.tile_ack = 1'b0;
        s = cyc;
        hung = 1'b0;
        for (int k = 0; k < n && !hung; k++) begin
            seen = 1'b0;
            waited = 0;
            while (!seen && waited < 40) begin
                @(negedge clk);
                if (bus.tile_valid) begin
                    seen = 1'b1;
                end else begin
                    bus.start    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                    bus.tile_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (noise) begin
                        bus.base_addr = ADDR_W'($urandom);
                        bus.num_tiles = TILE_W'($urandom);
                    end
                    waited++;
                end
            end
            bus.start = 1'b0;
            bus.tile_ack = 1'b0;
            if (!seen) begin
                chk_val($sformatf("tile%0d_timeout", k), 0, 1);
                hung = 1'b1;
            end else begin
                d = (dly < 0) ? $urandom_range(0, 6) : dly;
                repeat (d) @(negedge clk);
                bus.tile_ack = 1'b1;
                ack_c.push_back(cyc);
                @(negedge clk);
                bus.tile_ack = 1'b0;
            end
        end
        if (hung) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                bus.start = 1'b0;
                waited++;
            end
        end
        if (!seen) chk_val("done_timeout", 0, 1);
        @(negedge clk);

        ack_last = (n == 0) ? s : ack_c[n-1];
        chk_val("ren_count",  ren_cyc.size(), 4 * n);
        chk_val("read_count", rd_cyc.size(),  4 * n);
        chk_val("tv_count",   tv_cyc.size(),  n);
        for (int k = 0; k < n; k++) begin
            f = (k == 0) ? s + 1 : ack_c[k-1] + 1;
            for (int j = 0; j < 4; j++) begin
                i = 4 * k + j;
                a = (int'(base) + i) % DEPTH;
                if (i < ren_cyc.size()) begin
                    chk_val($sformatf("t%0d.w%0d.ren_cyc", k, j),  ren_cyc[i] - s, f + j - s);
                    chk_val($sformatf("t%0d.w%0d.ren_addr", k, j), ren_addr[i],    a);
                end
                if (i < rd_cyc.size()) begin
                    chk_val($sformatf("t%0d.w%0d.rd_cyc", k, j),  rd_cyc[i] - s, f + 2 + j - s);
                    chk_val($sformatf("t%0d.w%0d.rd_data", k, j), rd_data[i],    int'(sram[a]));
                end
            end
            if (k < tv_cyc.size()) begin
                eb = {sram[(int'(base) + 4*k) % DEPTH], sram[(int'(base) + 4*k + 1) % DEPTH],
                      sram[(int'(base) + 4*k + 2) % DEPTH], sram[(int'(base) + 4*k + 3) % DEPTH]};
                chk_val($sformatf("t%0d.tv_cyc", k), tv_cyc[k] - s, f + 6 - s);
                chk_val($sformatf("t%0d.tv_idx", k), tv_idx[k],     k);
                chk_val($sformatf("t%0d.slots", k),  tv_buf[k],     eb);
            end
        end
        chk_val("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk_val("done_cyc", done_cyc[0] - s, ack_last + 1 - s);
        chk_val("busy_cycles", busy_cyc.size(), ack_last - s);
        if (busy_cyc.size() > 0) begin
            chk_val("busy_first", busy_cyc[0] - s, 1);
            chk_val("busy_last",  busy_cyc[busy_cyc.size()-1] - s, ack_last - s);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_tiles = '0;
        bus.tile_ack  = 1'b0;
        for (int i = 0; i < DEPTH; i++) sram[i] = DATA_W'($urandom);
        sram[16] = 8'sd1;
        sram[17] = -8'sd2;
        sram[18] = 8'sd3;
        sram[19] = -8'sd4;

        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus.start     = 1'($urandom_range(0, 1));
            bus.base_addr = ADDR_W'($urandom);
            bus.num_tiles = TILE_W'($urandom);
            bus.tile_ack  = 1'($urandom_range(0, 1));
            #1 chk_quiet("in_reset");
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.base_addr = ADDR_W'($urandom);
            bus.num_tiles = TILE_W'($urandom);
            bus.tile_ack  = 1'($urandom_range(0, 1));
            #1 chk_quiet("idle");
        end
        bus.tile_ack = 1'b0;

        run_cmd(10'h010, 8'd1, 2, 1'b0);
        run_cmd(ADDR_W'($urandom), 8'd3, 5, 1'b0);
        run_cmd(10'h3FE, 8'd1, 0, 1'b0);
        run_cmd(ADDR_W'($urandom), 8'd0, 0, 1'b0);
        run_cmd(ADDR_W'($urandom), 8'd3, -1, 1'b1);

        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 10'h123; bus.num_tiles = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_val("mid_fetch_ren", bus.mem_ren, 1);
        rst_n = 1'b0;
        #1 chk_quiet("abort");
        repeat (3) begin
            @(negedge clk);
            chk_quiet("abort_hold");
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk_quiet("post_abort");
        end
        run_cmd(10'h123, 8'd2, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_cmd(ADDR_W'($urandom), TILE_W'($urandom_range(1, 5)), -1, 1'($urandom_range(0, 1)));
        end
        run_cmd(ADDR_W'($urandom), 8'd255, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
